// File: rtl/ego1_seq_ctrl.sv
// ego1_seq_ctrl: clocked sequencer for the two-input (x2,x1), two-state-variable
// (y2,y1) machine with output z. It synchronises and debounces the buttons, then
// admits one input change at a time. For each change it iterates the next-state
// equations until Y is stable, and shows state, inputs, status and z on led_pin.
// Optional build macro STEP_TRACE_EN adds an 8-bit counter of Y-changing
// evaluations, shown on led_pin[15:8]. When the macro is undefined those bits are 0.
module ego1_seq_ctrl #(
   parameter int unsigned      DEB_W      = 20,
   parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd1000000,
   parameter int unsigned      MAX_ITER   = 4
) (
   input  logic        sys_clk_in,
   input  logic        sys_rst_n,
   input  logic        btn_x2,
   input  logic        btn_x1,
   output logic [15:0] led_pin
);

   localparam int unsigned      IW        = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
   localparam logic [IW-1:0]    ITER_LAST = IW'(MAX_ITER - 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_CYCLES - DEB_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE, S_ERR} state_t;

   // Bit 1 of every X/Y vector is x2/y2 and bit 0 is x1/y1.
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_xd;
   logic [1:0]       r_prev_x;
   logic [1:0]       r_y;
   logic [DEB_W-1:0] r_deb_cnt [2];
   state_t           r_state;
   logic [IW-1:0]    r_iter;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_z;

   logic             w_n1;
   logic             w_n2;
   logic [1:0]       w_next;
   logic [1:0]       w_xdiff;
   logic [7:0]       w_trace;

   // Two-flop synchronisers bring both raw buttons into the clock domain.
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         // NOTE: non-blocking so each stage samples the pre-edge value; blocking would merge the two stages.
         r_sync1 <= {btn_x2, btn_x1};
         r_sync2 <= r_sync1;
      end
   end

   // Per-button debounce: a new level is accepted only after DEB_CYCLES stable cycles.
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_xd <= '0;
         // NOTE: the counter array is ordinary state, so each entry is reset explicitly rather than left undefined.
         r_deb_cnt[0] <= '0;
         r_deb_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_xd[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_xd[i]      <= r_sync2[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Next-state equations and input-change detection on the registered X and Y.
   always_comb begin
      // NOTE: defaults first so that no path through this block can infer a latch.
      w_n1    = 1'b0;
      w_n2    = 1'b0;
      w_xdiff = r_xd ^ r_prev_x;
      w_n1    = r_xd[0] | (r_y[0] & ~(r_xd[1] & r_y[1]));
      w_n2    = (~r_xd[1] & ~r_xd[0] & r_y[0]) | (r_xd[1] & r_y[1]);
      w_next  = {w_n2, w_n1};
   end

   // Sequencer: admit one input change, iterate Y to a fixed point, flag errors.
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state  <= S_IDLE;
         r_prev_x <= '0;
         r_y      <= '0;
         r_iter   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xdiff != 2'b00) begin
                  r_prev_x <= r_xd;
                  r_done   <= 1'b0;
                  if (w_xdiff == 2'b11) begin
                     // Both inputs moved at once, so the fundamental-mode assumption is broken.
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_EVAL;
                     r_iter  <= '0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_EVAL: begin
               r_y    <= w_next;
               r_iter <= r_iter + IW'(1);
               if (w_next == r_y) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (r_iter == ITER_LAST) begin
                  r_state <= S_ERR;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            S_ERR: begin
               // Y stays frozen until both inputs are released.
               if (r_xd == 2'b00) begin
                  r_state  <= S_IDLE;
                  r_err    <= 1'b0;
                  r_prev_x <= 2'b00;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Machine output z, registered from the registered X and Y.
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_z <= 1'b0;
      end else begin
         r_z <= r_xd[1] & r_y[1];
      end
   end

`ifdef STEP_TRACE_EN
   logic [1:0] r_y_entry;
   logic [7:0] r_trace;

   // Counts completed evaluations whose final Y differs from Y at evaluation entry.
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_y_entry <= '0;
         r_trace   <= '0;
      end else begin
         if (r_state == S_IDLE && (w_xdiff == 2'b01 || w_xdiff == 2'b10)) begin
            r_y_entry <= r_y;
         end
         if (r_state == S_DONE && r_y != r_y_entry) begin
            r_trace <= r_trace + 8'd1;
         end
      end
   end

   assign w_trace = r_trace;
`else
   assign w_trace = 8'h00;
`endif

   // Every LED bit comes straight from a flop, so the LEDs never glitch.
   assign led_pin = {w_trace, r_z, r_err, r_done, r_busy, r_xd[1], r_xd[0], r_y[0], r_y[1]};

endmodule
